// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, occupancy encoding and writeback entry type for the MEM/WB stage.
package mips_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} occ_t;
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
        logic                  regwrite;
    } wb_entry_t;
    // An entry forwards only if it will really write a non-zero register.
    function automatic logic fwd_match(input logic valid, input wb_entry_t e,
                                       input logic [REG_ADDR_W-1:0] q);
        return valid && e.regwrite && e.rd == q && e.rd != ZERO_REG;
    endfunction
endpackage

// File: rtl/wb_fifo2.sv
// wb_fifo2: two-entry in-order buffer holding resolved writeback entries.
module wb_fifo2
    import mips_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  logic      pop,
    input  logic      flush,
    input  wb_entry_t din,
    output occ_t      state,
    output wb_entry_t head,
    output wb_entry_t second
);
    occ_t      state_nx;
    wb_entry_t mem [2];
    logic      rptr, wptr;
    logic      do_push, do_pop;
    assign do_push = push && state != FULL;
    assign do_pop  = pop && state != EMPTY;
    assign head    = mem[rptr];
    assign second  = mem[~rptr];
    always_comb begin
        state_nx = state;
        state_nx = flush ? EMPTY
                 : state == EMPTY ? (do_push ? ONE : EMPTY)
                 : state == ONE   ? (do_push && !do_pop ? FULL : do_pop && !do_push ? EMPTY : ONE)
                 : (do_pop ? ONE : FULL);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else state <= state_nx;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rptr   <= 1'b0;
            wptr   <= 1'b0;
        end else if (flush) begin
            rptr <= 1'b0;
            wptr <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wptr] <= din;
                wptr      <= ~wptr;
            end
            if (do_pop) rptr <= ~rptr;
        end
    end
endmodule

// File: rtl/mem_wb_writeback.sv
// mem_wb_writeback: buffered register-file writeback with forwarding and retire counter.
module mem_wb_writeback
    import mips_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic [DATA_W-1:0]     in_alu_result,
    input  logic [DATA_W-1:0]     in_mem_data,
    input  logic                  in_memtoreg,
    input  logic                  in_regwrite,
    input  logic                  wb_stall,
    input  logic                  flush,
    output logic [REG_ADDR_W-1:0] rd,
    output logic [DATA_W-1:0]     writedata,
    output logic                  regwrite,
    input  logic [REG_ADDR_W-1:0] q_rs,
    input  logic [REG_ADDR_W-1:0] q_rt,
    output logic                  q_rs_hit,
    output logic                  q_rt_hit,
    output logic [DATA_W-1:0]     q_rs_data,
    output logic [DATA_W-1:0]     q_rt_data,
    output logic [31:0]           retired_count
);
    occ_t      state;
    wb_entry_t din, head, second;
    logic      head_valid, young_valid, push, pop;
    logic      rs_young, rs_head, rt_young, rt_head;
    assign din         = '{rd: in_rd, data: in_memtoreg ? in_mem_data : in_alu_result, regwrite: in_regwrite};
    assign head_valid  = state != EMPTY;
    assign young_valid = state == FULL;
    assign in_ready    = state != FULL;
    assign push        = in_valid && in_ready;
    assign pop         = head_valid && !wb_stall;
    wb_fifo2 u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (push),
        .pop    (pop),
        .flush  (flush),
        .din    (din),
        .state  (state),
        .head   (head),
        .second (second)
    );
    assign rd        = head_valid ? head.rd : ZERO_REG;
    assign writedata = head_valid ? head.data : '0;
    assign regwrite  = head_valid && head.regwrite && head.rd != ZERO_REG && !wb_stall;
    // The second slot is always the younger entry, so it takes priority.
    assign rs_young  = fwd_match(young_valid, second, q_rs);
    assign rs_head   = fwd_match(head_valid, head, q_rs);
    assign rt_young  = fwd_match(young_valid, second, q_rt);
    assign rt_head   = fwd_match(head_valid, head, q_rt);
    assign q_rs_hit  = rs_young || rs_head;
    assign q_rt_hit  = rt_young || rt_head;
    assign q_rs_data = rs_young ? second.data : rs_head ? head.data : '0;
    assign q_rt_data = rt_young ? second.data : rt_head ? head.data : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) retired_count <= '0;
        else if (pop && !flush) retired_count <= retired_count + 32'd1;
    end
endmodule

// File: tb/tb_mem_wb_writeback.sv
// tb_mem_wb_writeback: directed stimulus with a write-event scoreboard checked by a monitor.
module tb_mem_wb_writeback;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [4:0]  in_rd = '0;
    logic [31:0] in_alu_result = '0, in_mem_data = '0;
    logic        in_memtoreg = 1'b0, in_regwrite = 1'b0, wb_stall = 1'b0, flush = 1'b0;
    logic [4:0]  rd, q_rs = '0, q_rt = '0;
    logic [31:0] writedata, q_rs_data, q_rt_data, retired_count;
    logic        regwrite, q_rs_hit, q_rt_hit;
    int          errors = 0, checks = 0;
    logic [36:0] exp_q [$];

    mem_wb_writeback dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_alu_result(in_alu_result), .in_mem_data(in_mem_data),
        .in_memtoreg(in_memtoreg), .in_regwrite(in_regwrite), .wb_stall(wb_stall),
        .flush(flush), .rd(rd), .writedata(writedata), .regwrite(regwrite),
        .q_rs(q_rs), .q_rt(q_rt), .q_rs_hit(q_rs_hit), .q_rt_hit(q_rt_hit),
        .q_rs_data(q_rs_data), .q_rt_data(q_rt_data), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [4:0] r, input logic [31:0] alu, input logic [31:0] md,
                         input logic m2r, input logic rw);
        in_valid = 1'b1;
        in_rd = r;
        in_alu_result = alu;
        in_mem_data = md;
        in_memtoreg = m2r;
        in_regwrite = rw;
    endtask

    // Every register-file write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && regwrite) begin
            if (exp_q.size() == 0) chk("unexpected_write_rd", {27'd0, rd}, 32'hFFFF_FFFF);
            else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                chk("write_rd", {27'd0, rd}, {27'd0, e[36:32]});
                chk("write_data", writedata, e[31:0]);
            end
        end
    end

    initial begin
        #2;
        chk("reset_rd", {27'd0, rd}, 32'd0);
        chk("reset_writedata", writedata, 32'd0);
        chk("reset_regwrite", {31'd0, regwrite}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_retired", retired_count, 32'd0);
        step();
        rst_n = 1'b1;
        // plain ALU write
        offer(5'd2, 32'd27, 32'd99, 1'b0, 1'b1);
        exp_q.push_back({5'd2, 32'd27});
        step();
        in_valid = 1'b0;
        step();
        chk("s1_retired", retired_count, 32'd1);
        // load into r0: data visible but never written
        offer(5'd0, 32'd99, 32'd55, 1'b1, 1'b1);
        step();
        in_valid = 1'b0;
        chk("s2_regwrite", {31'd0, regwrite}, 32'd0);
        chk("s2_writedata", writedata, 32'd55);
        step();
        chk("s2_retired", retired_count, 32'd2);
        // stall fills the buffer; release drains in order
        wb_stall = 1'b1;
        offer(5'd3, 32'd30, 32'd0, 1'b0, 1'b1);
        step();
        offer(5'd5, 32'd50, 32'd0, 1'b0, 1'b1);
        step();
        chk("s3_full_ready", {31'd0, in_ready}, 32'd0);
        offer(5'd7, 32'd70, 32'd0, 1'b0, 1'b1);
        exp_q.push_back({5'd3, 32'd30});
        exp_q.push_back({5'd5, 32'd50});
        exp_q.push_back({5'd7, 32'd70});
        step();
        chk("s3_held_ready", {31'd0, in_ready}, 32'd0);
        chk("s3_frozen_rd", {27'd0, rd}, 32'd3);
        chk("s3_stalled_regwrite", {31'd0, regwrite}, 32'd0);
        chk("s3_stalled_retired", retired_count, 32'd2);
        wb_stall = 1'b0;
        step();
        chk("s3_ready_after_pop", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        chk("s3_third_head", {27'd0, rd}, 32'd7);
        step();
        chk("s3_retired", retired_count, 32'd5);
        chk("s3_empty_rd", {27'd0, rd}, 32'd0);
        // forwarding: youngest match wins
        wb_stall = 1'b1;
        offer(5'd4, 32'd10, 32'd0, 1'b0, 1'b1);
        step();
        offer(5'd4, 32'd20, 32'd0, 1'b0, 1'b1);
        step();
        in_valid = 1'b0;
        q_rs = 5'd4;
        q_rt = 5'd9;
        #1;
        chk("s4_rs_hit", {31'd0, q_rs_hit}, 32'd1);
        chk("s4_rs_data", q_rs_data, 32'd20);
        chk("s4_rt_hit", {31'd0, q_rt_hit}, 32'd0);
        chk("s4_rt_data", q_rt_data, 32'd0);
        // flush beats push and pop; head still drives regwrite this cycle
        flush = 1'b1;
        wb_stall = 1'b0;
        offer(5'd11, 32'd111, 32'd0, 1'b0, 1'b1);
        exp_q.push_back({5'd4, 32'd10});
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("s5_in_ready", {31'd0, in_ready}, 32'd1);
        chk("s5_rd", {27'd0, rd}, 32'd0);
        chk("s5_retired", retired_count, 32'd5);
        chk("s5_rs_hit", {31'd0, q_rs_hit}, 32'd0);
        step();
        // asynchronous reset while full
        wb_stall = 1'b1;
        offer(5'd12, 32'd120, 32'd0, 1'b0, 1'b1);
        step();
        offer(5'd13, 32'd130, 32'd0, 1'b0, 1'b1);
        step();
        in_valid = 1'b0;
        q_rs = 5'd12;
        chk("s6_full", {31'd0, in_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6_rd", {27'd0, rd}, 32'd0);
        chk("s6_writedata", writedata, 32'd0);
        chk("s6_regwrite", {31'd0, regwrite}, 32'd0);
        chk("s6_in_ready", {31'd0, in_ready}, 32'd1);
        chk("s6_retired", retired_count, 32'd0);
        chk("s6_rs_hit", {31'd0, q_rs_hit}, 32'd0);
        wb_stall = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("s6_after_rd", {27'd0, rd}, 32'd0);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
